// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads a combinational ROM and queues
// {pc, instr} pairs in a small FIFO for decode, with start, redirect/flush and halt.
module fetch_sequencer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] END_PC   = 32'h104
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        busy,
  output logic        halted
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e        r_state, w_state_next;
  logic [31:0]   r_pc, w_pc_next;
  logic [31:0]   r_fifo_pc    [DEPTH];
  logic [31:0]   r_fifo_instr [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_active, w_redirect, w_valid, w_full, w_fire, w_in_range, w_push, w_start_ok;

  assign w_active   = (r_state == StRun) || (r_state == StDrain);
  assign w_redirect = redirect_valid && w_active;
  assign w_valid    = (r_count != '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_fire     = w_valid && out_ready;
  assign w_in_range = (r_pc < END_PC);
  assign w_start_ok = start && ((r_state == StIdle) || (r_state == StDone));
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign w_push     = (r_state == StRun) && !w_redirect && (!w_full || w_fire) && w_in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StRun;
      StRun: begin
        if (w_redirect)       w_state_next = StRun;
        else if (!w_in_range) w_state_next = StDrain;
      end
      StDrain: begin
        if (w_redirect)       w_state_next = StRun;
        else if (!w_valid)    w_state_next = StDone;
      end
      StDone:  if (start) w_state_next = StRun;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    busy      = w_active;
    halted    = (r_state == StDone);
    imem_addr = r_pc;
    out_valid = w_valid;
    out_pc    = w_valid ? r_fifo_pc[r_rd_ptr]    : 32'h0;
    out_instr = w_valid ? r_fifo_instr[r_rd_ptr] : 32'h0;
  end

  always_comb begin
    w_pc_next = r_pc;
    if (w_start_ok)      w_pc_next = RESET_PC;
    else if (w_redirect) w_pc_next = {redirect_pc[31:2], 2'b00};
    else if (w_push)     w_pc_next = r_pc + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_redirect) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_fire) r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_fire);
      end
    end
  end

  // Storage needs no reset: entries are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_pc;
      r_fifo_instr[r_wr_ptr] <= imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: cycle vector table plus hand-written
// sequences for full program run, redirect skip, async reset and DONE behaviour.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        busy;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h000: return 32'h8c19003b;
      32'h004: return 32'h8c18003a;
      32'h070: return 32'h02098020;
      32'h100: return 32'hac190064;
      default: return {16'hc0de, a[15:0]};
    endcase
  endfunction

  assign imem_data = rom(imem_addr);

  fetch_sequencer #(
    .DEPTH   (4),
    .RESET_PC(32'h0),
    .END_PC  (32'h104)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .busy          (busy),
    .halted        (halted)
  );

  typedef struct {
    logic        start;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        valid;
    logic [31:0] opc;
    logic [31:0] oinstr;
    logic [31:0] addr;
    logic        busy;
    logic        halted;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    start          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nf;
    int          bad;
    logic [31:0] exp_pc;

    // start, ready, redir, rpc | valid, out_pc, out_instr, imem_addr, busy, halted
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,        32'h0,  1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  32'h8c19003b, 32'h4,  1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  32'h8c19003b, 32'h8,  1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  32'h8c19003b, 32'hc,  1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  32'h8c19003b, 32'h10, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  32'h8c19003b, 32'h10, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  32'h8c18003a, 32'h14, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h8,  32'hc0de0008, 32'h18, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'hc0de0008, 32'h18, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h93, 1'b0, 32'h0,  32'h0,        32'h90, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h90, 32'hc0de0090, 32'h94, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 32'h94, 32'hc0de0094, 32'h98, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h94, 32'hc0de0094, 32'h9c, 1'b1, 1'b0};

    // Reset state
    do_reset();
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_pc",    out_pc,         32'h0);
    check("rst_instr", out_instr,      32'h0);
    check("rst_addr",  imem_addr,      32'h0);
    check("rst_busy",  32'(busy),      32'h0);
    check("rst_halt",  32'(halted),    32'h0);

    // Fill with ready low, drain, redirect with fire, ignored start
    for (int i = 0; i < 13; i++) begin
      start          = vecs[i].start;
      out_ready      = vecs[i].ready;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      step();
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].valid));
      check($sformatf("vec%0d_pc", i),    out_pc,         vecs[i].opc);
      check($sformatf("vec%0d_instr", i), out_instr,      vecs[i].oinstr);
      check($sformatf("vec%0d_addr", i),  imem_addr,      vecs[i].addr);
      check($sformatf("vec%0d_busy", i),  32'(busy),      32'(vecs[i].busy));
      check($sformatf("vec%0d_halt", i),  32'(halted),    32'(vecs[i].halted));
    end
    start          = 1'b0;
    redirect_valid = 1'b0;

    // Full program with ready held high
    do_reset();
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    check("t1_lat_n", 32'(out_valid), 32'h0);
    step();
    check("t1_lat_n1", 32'(out_valid), 32'h1);
    exp_pc = 32'h0;
    nf     = 0;
    for (int c = 0; c < 200; c++) begin
      if (halted) break;
      if (out_valid) begin
        check("t1_pc",    out_pc,    exp_pc);
        check("t1_instr", out_instr, rom(exp_pc));
        exp_pc += 32'd4;
        nf++;
      end
      step();
    end
    check("t1_fires",  32'(nf),     32'd65);
    check("t1_halted", 32'(halted), 32'h1);
    check("t1_busy",   32'(busy),   32'h0);

    // Redirect to 0x70 while 0x24 is at the head
    do_reset();
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (out_valid && out_pc == 32'h24) break;
      step();
    end
    check("t3_reach", out_pc, 32'h24);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h70;
    step();
    redirect_valid = 1'b0;
    check("t3_flush_valid", 32'(out_valid), 32'h0);
    step();
    check("t3_first_valid", 32'(out_valid), 32'h1);
    check("t3_first_pc",    out_pc,         32'h70);
    check("t3_first_instr", out_instr,      32'h02098020);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (out_valid && out_pc >= 32'h28 && out_pc <= 32'h6c) bad++;
    end
    check("t3_skipped", 32'(bad), 32'h0);

    // Asynchronous reset mid-run with three entries queued
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check("t5_pre_valid", 32'(out_valid), 32'h1);
    check("t5_pre_addr",  imem_addr,      32'hc);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(out_valid), 32'h0);
    check("t5_async_busy",  32'(busy),      32'h0);
    check("t5_async_addr",  imem_addr,      32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) step();
    check("t5_post_valid", 32'(out_valid), 32'h0);
    check("t5_post_busy",  32'(busy),      32'h0);

    // DONE ignores redirect, then restarts on start
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (halted) break;
      step();
    end
    check("t6_halted", 32'(halted), 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    step();
    redirect_valid = 1'b0;
    check("t6_redir_halted", 32'(halted),    32'h1);
    check("t6_redir_valid",  32'(out_valid), 32'h0);
    check("t6_redir_addr",   imem_addr,      32'h104);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("t6_restart_valid", 32'(out_valid), 32'h1);
    check("t6_restart_pc",    out_pc,         32'h0);
    check("t6_restart_instr", out_instr,      32'h8c19003b);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
